// File: rtl/max_pool_engine_pkg.sv
// max_pool_engine_pkg: shared FSM state, mode encodings and lane-width helper for the pooling engine.
package max_pool_engine_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    typedef enum logic {MODE_S2 = 1'b0, MODE_S1 = 1'b1} mode_t;
    localparam int BASE_WIDTH = 8;
    localparam int LANE_W = BASE_WIDTH * 2;
    function automatic int lane_w(input int data_width);
        return data_width * 2;
    endfunction
endpackage

// File: rtl/max_pool_engine_if.sv
// max_pool_engine_if: control, input-row and output-row handshake bundle for the pooling engine.
interface max_pool_engine_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_MODULES = 16,
    parameter int ROW_W       = 10
);
    localparam int BW = DATA_WIDTH * 2 * NUM_MODULES;
    logic             start;
    logic             mode;
    logic [ROW_W-1:0] rows_cfg;
    logic             in_valid;
    logic             in_ready;
    logic [BW-1:0]    in_data;
    logic             out_valid;
    logic             out_ready;
    logic [BW-1:0]    out_data;
    logic             out_last;
    logic             busy;
    modport master (
        output start, mode, rows_cfg, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );
    modport slave (
        input  start, mode, rows_cfg, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/max2_signed.sv
// max2_signed: two-input signed maximum, shared by the horizontal and vertical pooling stages.
module max2_signed #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y
);
    assign y = (a > b) ? a : b;
endmodule

// File: rtl/max_pool_engine.sv
// max_pool_engine: streaming 2x2 max pooling over row beats, stride 2 or stride 1 with edge replication.
module max_pool_engine
    import max_pool_engine_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_MODULES = 16,
    parameter int ROW_W       = 10
) (
    input logic clk,
    input logic rst_n,
    max_pool_engine_if.slave bus
);
    localparam int LW   = lane_w(DATA_WIDTH);
    localparam int HALF = NUM_MODULES / 2;
    localparam int BW   = LW * NUM_MODULES;

    state_t           state;
    mode_t            mode_r;
    logic [ROW_W-1:0] rows_r;
    logic [ROW_W-1:0] cnt;
    logic [BW-1:0]    linebuf;
    logic [BW-1:0]    out_data;
    logic             out_valid;
    logic             out_last;
    logic [BW-1:0]    h;
    logic [BW-1:0]    v;
    logic             out_free;
    logic             in_fire;
    logic             last_row;

    for (genvar g = 0; g < NUM_MODULES; g++) begin : g_lane
        localparam int A0 = g;
        localparam int A1 = (g == NUM_MODULES - 1) ? g : g + 1;
        localparam int B0 = (2 * g) % NUM_MODULES;
        localparam int B1 = (2 * g + 1) % NUM_MODULES;
        localparam bit UP = (g >= HALF);
        logic signed [LW-1:0] ha, hb, hm;
        assign ha = (mode_r == MODE_S1) ? bus.in_data[A0*LW +: LW] : bus.in_data[B0*LW +: LW];
        assign hb = (mode_r == MODE_S1) ? bus.in_data[A1*LW +: LW] : bus.in_data[B1*LW +: LW];
        max2_signed #(.W(LW)) u_h (.a(ha), .b(hb), .y(hm));
        // Stride-2 only fills the lower half of the output row.
        assign h[g*LW +: LW] = (mode_r == MODE_S2 && UP) ? '0 : hm;
        max2_signed #(.W(LW)) u_v (.a(h[g*LW +: LW]), .b(linebuf[g*LW +: LW]), .y(v[g*LW +: LW]));
    end

    assign out_free      = !out_valid || bus.out_ready;
    assign bus.in_ready  = (state == RUN) && (cnt != rows_r) && out_free;
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign last_row      = (cnt == rows_r - 1'b1);
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_last  = out_last;
    assign bus.busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_r    <= MODE_S2;
            rows_r    <= '0;
            cnt       <= '0;
            linebuf   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (bus.out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            unique case (state)
                IDLE: if (bus.start) begin
                    state   <= RUN;
                    mode_r  <= mode_t'(bus.mode);
                    rows_r  <= (bus.rows_cfg == '0) ? ROW_W'(1) : bus.rows_cfg;
                    cnt     <= '0;
                    linebuf <= '0;
                end
                RUN: begin
                    if (in_fire) begin
                        cnt <= cnt + 1'b1;
                        if (mode_r == MODE_S1) begin
                            linebuf <= h;
                            if (cnt != '0) begin
                                out_valid <= 1'b1;
                                out_data  <= v;
                                out_last  <= 1'b0;
                            end
                            if (last_row) state <= FLUSH;
                        end else if (!cnt[0] && !last_row) begin
                            linebuf <= h;
                        end else begin
                            out_valid <= 1'b1;
                            out_data  <= cnt[0] ? v : h;
                            out_last  <= last_row;
                        end
                    end
                    // Stride-2 frames end once the beat flagged last is taken.
                    if (out_valid && out_last && bus.out_ready) state <= IDLE;
                end
                FLUSH: begin
                    if (out_valid && out_last) begin
                        if (bus.out_ready) state <= IDLE;
                    end else if (out_free) begin
                        out_valid <= 1'b1;
                        out_data  <= linebuf;
                        out_last  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_max_pool_engine.sv
// tb_max_pool_engine: scoreboard bench comparing the pooling engine against a row-level reference model.
module tb_max_pool_engine;
    localparam int DW = 8;
    localparam int NM = 4;
    localparam int RW = 10;
    localparam int LW = DW * 2;
    localparam int FW = LW * NM;

    typedef logic [FW-1:0] flat_t;
    typedef logic signed [LW-1:0] lane_t;
    typedef struct packed {logic last; flat_t data;} beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    max_pool_engine_if #(.DATA_WIDTH(DW), .NUM_MODULES(NM), .ROW_W(RW)) bus ();
    max_pool_engine #(.DATA_WIDTH(DW), .NUM_MODULES(NM), .ROW_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int    checks = 0;
    int    errors = 0;
    beat_t sb[$];
    flat_t rows[$];
    int    hold = 0;
    bit    rnd_rdy = 1'b0;

    task automatic chk(input string nm, input flat_t act, input flat_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic flat_t mk(input int a0, input int a1, input int a2, input int a3);
        flat_t f;
        f[0*LW +: LW] = LW'(a0);
        f[1*LW +: LW] = LW'(a1);
        f[2*LW +: LW] = LW'(a2);
        f[3*LW +: LW] = LW'(a3);
        return f;
    endfunction

    function automatic lane_t ln(input flat_t f, input int i);
        return f[i*LW +: LW];
    endfunction

    function automatic lane_t mx(input lane_t a, input lane_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic flat_t hrow(input flat_t f, input bit m);
        flat_t r = '0;
        for (int i = 0; i < NM; i++) begin
            if (m) r[i*LW +: LW] = mx(ln(f, i), ln(f, (i == NM - 1) ? i : i + 1));
            else if (i < NM / 2) r[i*LW +: LW] = mx(ln(f, 2 * i), ln(f, 2 * i + 1));
        end
        return r;
    endfunction

    function automatic flat_t vmax(input flat_t a, input flat_t b);
        flat_t r;
        for (int i = 0; i < NM; i++) r[i*LW +: LW] = mx(ln(a, i), ln(b, i));
        return r;
    endfunction

    flat_t pd;
    logic  pl;
    bit    ps = 1'b0;
    beat_t e;
    always @(negedge clk) begin
        if (!rst_n) ps = 1'b0;
        else begin
            if (ps) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", bus.out_data, pd);
                chk("hold_last", bus.out_last, pl);
            end
            if (bus.out_valid && !bus.out_ready) chk("in_ready_stall", bus.in_ready, 0);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h expected none", bus.out_data);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", bus.out_data, e.data);
                    chk("out_last", bus.out_last, e.last);
                end
            end
            ps = bus.out_valid && !bus.out_ready;
            pd = bus.out_data;
            pl = bus.out_last;
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold > 0) begin
                bus.out_ready = 1'b0;
                hold--;
            end else bus.out_ready = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    task automatic send_row(input flat_t d, input bit prod);
        int to = 0;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        do begin
            @(negedge clk);
            to++;
        end while (!bus.in_ready && to < 500);
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data = {$urandom, $urandom};
        if (prod) chk("latency_out_valid", bus.out_valid, 1);
    endtask

    task automatic wait_done();
        int t = 0;
        while ((sb.size() != 0 || bus.busy) && t < 3000) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk("frame_done", flat_t'(t < 3000), 1);
        chk("out_valid_idle", bus.out_valid, 0);
    endtask

    task automatic run_frame(input bit m, input int cfg);
        int    r = (cfg == 0) ? 1 : cfg;
        flat_t h[$];
        beat_t b;
        for (int k = 0; k < r; k++) h.push_back(hrow(rows[k], m));
        if (!m) begin
            for (int k = 0; k < r; k += 2) begin
                b.last = (k + 2 >= r);
                b.data = (k + 1 < r) ? vmax(h[k], h[k+1]) : h[k];
                sb.push_back(b);
            end
        end else begin
            for (int k = 1; k < r; k++) begin
                b.last = 1'b0;
                b.data = vmax(h[k-1], h[k]);
                sb.push_back(b);
            end
            b.last = 1'b1;
            b.data = h[r-1];
            sb.push_back(b);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.mode = m;
        bus.rows_cfg = RW'(cfg);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_after_start", bus.busy, 1);
        for (int k = 0; k < r; k++) begin
            if (k == 1) begin
                bus.start = 1'b1;
                bus.mode = ~m;
                bus.rows_cfg = RW'(5);
                @(posedge clk);
                #1;
                bus.start = 1'b0;
                bus.mode = m;
                hold = 5;
            end
            send_row(rows[k], m ? (k >= 1) : (k % 2 == 1 || k == r - 1));
        end
        wait_done();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.mode = 1'b0;
        bus.rows_cfg = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_data", bus.out_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = mk(9, 9, 9, 9);
        repeat (3) begin
            @(negedge clk);
            chk("idle_in_ready", bus.in_ready, 0);
            chk("idle_out_valid", bus.out_valid, 0);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;

        rows = '{mk(1, 5, -3, 2), mk(4, 0, 7, -8)};
        run_frame(1'b0, 2);
        run_frame(1'b1, 2);
        rows = '{mk(1, 5, -3, 2), mk(4, 0, 7, -8), mk(-6, 3, 10, -1)};
        run_frame(1'b0, 3);
        run_frame(1'b1, 3);
        rows = '{mk(-32768, -32768, -32768, -32768), mk(-1, -1, -1, -1)};
        run_frame(1'b0, 2);
        run_frame(1'b1, 2);
        rows = '{mk(3, -4, 8, 0)};
        run_frame(1'b1, 1);
        run_frame(1'b0, 0);
        run_frame(1'b1, 0);

        rows = '{mk(100, 200, 300, 400)};
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.mode = 1'b0;
        bus.rows_cfg = RW'(4);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        send_row(rows[0], 1'b0);
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_out_valid", bus.out_valid, 0);
            chk("midrst_busy", bus.busy, 0);
            chk("midrst_in_ready", bus.in_ready, 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rows = '{mk(-5, -7, -9, -2), mk(-3, -8, -1, -6)};
        run_frame(1'b0, 2);
        run_frame(1'b1, 2);

        for (int f = 0; f < 25; f++) begin
            bit m = 1'($urandom_range(0, 1));
            int cfg = $urandom_range(0, 6);
            rnd_rdy = 1'($urandom_range(0, 1));
            rows.delete();
            for (int k = 0; k < ((cfg == 0) ? 1 : cfg); k++) rows.push_back({$urandom, $urandom});
            run_frame(m, cfg);
        end
        rnd_rdy = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
